// File: rtl/inner_fn_lat_fxd.sv
// inner_fn_lat_fxd: fixed-latency f(x) = 0.5*x + x^2*cos((x-128)/128) on an IEEE-754 single input
module inner_fn_lat_fxd (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done
);
    localparam int CORDIC_ITERS = 16;
    localparam logic signed [31:0] K_INIT = 32'sd2547003;
    localparam logic signed [31:0] ATAN [16] = '{
        32'sd3294199, 32'sd1944679, 32'sd1027515, 32'sd521583,
        32'sd261803,  32'sd131029,  32'sd65531,   32'sd32767,
        32'sd16384,   32'sd8192,    32'sd4096,    32'sd2048,
        32'sd1024,    32'sd512,     32'sd256,     32'sd128
    };

    typedef enum logic [2:0] {IDLE, CONV, ANGLE, ROT, MUL, PACK} state_t;

    state_t             state_q;
    logic        [30:0] raw_q;
    logic        [23:0] x_q;
    logic signed [31:0] cx_q, cy_q, cz_q;
    logic        [3:0]  it_q;
    logic        [31:0] p_q;
    logic        [31:0] result_q;
    logic               done_q;

    logic        [23:0] fix_d;
    logic signed [31:0] cx_d, cy_d, cz_d;
    logic        [47:0] sq_d;
    logic signed [79:0] term_d;
    logic        [31:0] p_d;
    logic        [4:0]  msb_d;
    logic        [22:0] mant_d;
    logic        [31:0] flt_d;
    logic               unused_sign;

    assign unused_sign = dataa[31];

    // Float to unsigned Q8.16; sign dropped, zero/denormal exponent gives zero
    always_comb begin
        fix_d = raw_q[30:23] == 8'd0 ? 24'd0 :
                raw_q[30:23] >= 8'd134 ? {1'b1, raw_q[22:0]} << (raw_q[30:23] - 8'd134) :
                {1'b1, raw_q[22:0]} >> (8'd134 - raw_q[30:23]);
    end

    // One CORDIC rotation-mode micro-step, direction from the sign of the residual angle
    always_comb begin
        cx_d = cz_q[31] ? cx_q + (cy_q >>> it_q) : cx_q - (cy_q >>> it_q);
        cy_d = cz_q[31] ? cy_q - (cx_q >>> it_q) : cy_q + (cx_q >>> it_q);
        cz_d = cz_q[31] ? cz_q + ATAN[it_q] : cz_q - ATAN[it_q];
    end

    // x^2 (Q16.32) times cos (Q.22) back to Q16.16, plus x/2
    always_comb begin
        sq_d   = {24'd0, x_q} * {24'd0, x_q};
        term_d = $signed({32'd0, sq_d}) * $signed({{48{cx_q[31]}}, cx_q});
        p_d    = 32'(term_d >>> 38) + {9'd0, x_q[23:1]};
    end

    // Q16.16 to float: leading-one search, truncating normalisation
    always_comb begin
        msb_d = 5'd0;
        for (int i = 0; i < 32; i++) msb_d = p_q[i] ? 5'(i) : msb_d;
        mant_d = 23'((p_q << (5'd31 - msb_d)) >> 8);
        flt_d  = p_q == 32'd0 ? 32'd0 : {1'b0, 8'({3'd0, msb_d} + 8'd111), mant_d};
    end

    // Sequencer: CONV, ANGLE, CORDIC_ITERS rotations, MUL, PACK -> done
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q  <= IDLE;
            raw_q    <= '0;
            x_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            cz_q     <= '0;
            it_q     <= '0;
            p_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    raw_q   <= dataa[30:0];
                    state_q <= CONV;
                end
                CONV: begin
                    x_q     <= fix_d;
                    state_q <= ANGLE;
                end
                ANGLE: begin
                    cx_q    <= K_INIT;
                    cy_q    <= '0;
                    cz_q    <= ($signed({8'd0, x_q}) - 32'sd8388608) >>> 1;
                    it_q    <= '0;
                    state_q <= ROT;
                end
                ROT: begin
                    cx_q    <= cx_d;
                    cy_q    <= cy_d;
                    cz_q    <= cz_d;
                    it_q    <= it_q + 4'd1;
                    state_q <= it_q == 4'(CORDIC_ITERS - 1) ? MUL : ROT;
                end
                MUL: begin
                    p_q     <= p_d;
                    state_q <= PACK;
                end
                PACK: begin
                    result_q <= flt_d;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
endmodule

// File: tb/tb_inner_fn_lat_fxd.sv
// tb_inner_fn_lat_fxd: random and directed checks of inner_fn_lat_fxd against a real-valued model
module tb_inner_fn_lat_fxd;
    logic        clock = 1'b0;
    logic        aclr = 1'b1;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] result;
    logic        done;
    int          total = 0;
    int          bad = 0;

    inner_fn_lat_fxd dut (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .result(result), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input real obs, input real exp, input real tol);
        total++;
        if (obs - exp > tol || exp - obs > tol) begin
            bad++;
            $display("FAIL %s: got %f want %f (tol %f)", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [31:0] to_float(input int n);
        int k;
        logic [31:0] m;
        k = 0;
        for (int i = 0; i < 31; i++) if (n >= (1 << i)) k = i;
        m = 32'(n) << (23 - k);
        return n == 0 ? 32'd0 : {1'b0, 8'(k + 119), m[22:0]};
    endfunction

    function automatic real to_real(input logic [31:0] b);
        real m;
        m = real'({9'd1, b[22:0]});
        return b[30:0] == 31'd0 ? 0.0 : m * (2.0 ** (real'(int'(b[30:23])) - 150.0));
    endfunction

    function automatic real fref(input real x);
        return 0.5 * x + x * x * $cos((x - 128.0) / 128.0);
    endfunction

    task automatic run(input logic [31:0] a, input int gap, input int pulse, output int lat);
        dataa = a;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            clk_en = !(gap >= 0 && lat >= gap && lat < gap + 3);
            start = (lat == pulse);
            @(negedge clock);
            lat++;
        end
        clk_en = 1'b1;
        start = 1'b0;
    endtask

    task automatic op(input string tag, input int n, input int gap, input int pulse, input int want_lat);
        int lat;
        real f;
        run(to_float(n), gap, pulse, lat);
        f = fref(real'(n) / 256.0);
        check({tag, "_lat"}, real'(lat), real'(want_lat), 0.0);
        check({tag, "_val"}, to_real(result), f, 2.0e-4 * f + 1.0e-3);
    endtask

    task automatic watch(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    initial begin
        int lat, cnt;
        logic [31:0] held;
        int dir [6] = '{25, 50, 100, 225, 255, 128};
        repeat (3) @(negedge clock);
        check("rst_result", real'(result), 0.0, 0.0);
        check("rst_done", real'(done), 0.0, 0.0);
        aclr = 1'b0;
        @(negedge clock);

        run(32'h0000_0000, -1, -1, lat);
        check("zero_lat", real'(lat), 20.0, 0.0);
        check("zero_bits", real'(result), 0.0, 0.0);

        foreach (dir[i]) begin
            op($sformatf("dir%0d", dir[i]), dir[i] * 256, -1, -1, 20);
            held = result;
            @(negedge clock);
            check("done_width", real'(done), 0.0, 0.0);
            check("result_hold", real'(result), real'(held), 0.0);
        end

        run(32'h8000_0000, -1, -1, lat);
        check("negzero_bits", real'(result), 0.0, 0.0);

        for (int i = 0; i < 20; i++)
            op($sformatf("rnd%0d", i), int'($urandom_range(0, 65280)), -1, -1, 20);

        for (int v = 0; v <= 255; v = (v == 250) ? 255 : v + 25)
            op($sformatf("sweep%0d", v), v * 256, -1, -1, 20);

        @(negedge clock);
        op("gap", int'($urandom_range(0, 65280)), 5, -1, 23);
        op("gap_early", int'($urandom_range(0, 65280)), 0, -1, 23);

        op("busy", 100 * 256, -1, 7, 20);
        watch(25, cnt);
        check("busy_no_relaunch", real'(cnt), 0.0, 0.0);

        dataa = to_float(200 * 256);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        #2 aclr = 1'b1;
        #1;
        check("abort_result", real'(result), 0.0, 0.0);
        check("abort_done", real'(done), 0.0, 0.0);
        @(negedge clock);
        aclr = 1'b0;
        watch(30, cnt);
        check("abort_no_done", real'(cnt), 0.0, 0.0);
        op("after_abort", 50 * 256, -1, -1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
